// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, geometry,
// column reset pattern and the row/column-to-key-code helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;
  localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_e;

  // Index of the lowest-numbered low (active) bit; lowest index wins on ties.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // key_code = row_index*4 + col_index, with lowest-row priority.
  function automatic logic [3:0] key_code_of(input logic [NUM_ROWS-1:0] row_pat,
                                             input logic [NUM_COLS-1:0] col_pat);
    return {low_index(row_pat), low_index(col_pat)};
  endfunction

  // Next column in the scan rotation: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [NUM_COLS-1:0] col_advance(input logic [NUM_COLS-1:0] c);
    return {c[NUM_COLS-2:0], c[NUM_COLS-1]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick_o is high for one clk every SCAN_DIV clks.
module tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero after the last position of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register; runs regardless of the scanner state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces
// press and release on scan ticks, and reports the accepted key code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  logic                tick_s;
  logic [NUM_ROWS-1:0] sync1_q;
  logic [NUM_ROWS-1:0] sync2_q;
  logic [NUM_ROWS-1:0] rs;
  logic [NUM_ROWS-1:0] pat_q;
  logic [7:0]          cnt_q;
  logic                db_done_s;
  state_e              state_q;
  logic [NUM_COLS-1:0] col_q;
  logic [3:0]          key_code_q;
  logic                key_valid_q;
  logic                key_held_q;

  tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick_s)
  );

  // Two-flop synchronizer for the asynchronous, pulled-up row lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= ROWS_IDLE;
      sync2_q <= ROWS_IDLE;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  assign rs = sync2_q;

  // The sample taken on this tick completes the debounce window.
  always_comb begin
    db_done_s = 1'b0;
    if (({1'b0, cnt_q} + 9'd1) >= 9'(DEBOUNCE_TICKS)) begin
      db_done_s = 1'b1;
    end else begin
      db_done_s = 1'b0;
    end
  end

  // Scan/debounce FSM with registered column drive and key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_q       <= COL_RESET;
      pat_q       <= ROWS_IDLE;
      cnt_q       <= 8'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick_s) begin
        case (state_q)
          ST_SCAN: begin
            if (rs == ROWS_IDLE) begin
              col_q <= col_advance(col_q);
            end else begin
              pat_q   <= rs;
              cnt_q   <= 8'd1;
              state_q <= ST_PRESS_DB;
            end
          end
          ST_PRESS_DB: begin
            if (rs == pat_q) begin
              if (db_done_s) begin
                state_q     <= ST_HELD;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                key_code_q  <= key_code_of(pat_q, col_q);
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end else begin
              // Bounce or early release: abandon and move on to the next column.
              state_q <= ST_SCAN;
              col_q   <= col_advance(col_q);
            end
          end
          ST_HELD: begin
            // Any other key pressed meanwhile is ignored; only a full release counts.
            if (rs == ROWS_IDLE) begin
              cnt_q   <= 8'd1;
              state_q <= ST_RELEASE_DB;
            end
          end
          ST_RELEASE_DB: begin
            if (rs == ROWS_IDLE) begin
              if (db_done_s) begin
                state_q    <= ST_SCAN;
                key_held_q <= 1'b0;
                col_q      <= col_advance(col_q);
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
          default: begin
            state_q    <= ST_SCAN;
            col_q      <= COL_RESET;
            key_held_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_TICKS=3) with a
// simple keypad model: row r is pulled low when col c is low and key (r,c) is down.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;

  int compared;
  int mismatched;
  int exp_q[$];

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = ~(|(pressed[r] & ~col));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse must match the next expected code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: got key_valid with code %0d, expected no pulse", key_code);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (key_code !== 4'(e) || key_held !== 1'b1) begin
          mismatched++;
          $display("FAIL pulse_code: got code %0d held %0b, expected code %0d held 1",
                   key_code, key_held, e);
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for a few cycles, check reset state, release just after a posedge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    clks(3);
    @(negedge clk);
    chk({tag, "_rst_col"},   int'(col), 4'b1110);
    chk({tag, "_rst_valid"}, int'(key_valid), 0);
    chk({tag, "_rst_held"},  int'(key_held), 0);
    chk({tag, "_rst_code"},  int'(key_code), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_tbl [4];
    logic [3:0] c0;
    int dropped;
    col_tbl[0] = 4'b1110;
    col_tbl[1] = 4'b1101;
    col_tbl[2] = 4'b1011;
    col_tbl[3] = 4'b0111;
    compared   = 0;
    mismatched = 0;
    pressed    = '0;
    reset      = 1'b1;

    // Idle scanning: column rotates every 4 clks, no pulses.
    do_reset("idle");
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("idle_col", int'(col), int'(col_tbl[(k / 4) % 4]));
    end

    // Key (2,1): single accept with code 9, release debounced over 3 ticks.
    do_reset("k21");
    exp_q.push_back(9);
    pressed[2][1] = 1'b1;
    clks(100);
    chk("k21_pending", exp_q.size(), 0);
    chk("k21_held", int'(key_held), 1);
    pressed = '0;
    clks(6);
    chk("k21_held_early_release", int'(key_held), 1);
    clks(14);
    chk("k21_held_after_release", int'(key_held), 0);
    chk("k21_code_kept", int'(key_code), 9);

    // Key (0,3) bouncing once per tick period: never accepted.
    do_reset("bounce");
    for (int i = 0; i < 12; i++) begin
      pressed[0][3] = 1'b1;
      clks(4);
      pressed[0][3] = 1'b0;
      clks(4);
    end
    @(negedge clk);
    c0 = col;
    clks(8);
    chk("bounce_scan_runs", int'(col != c0), 1);
    chk("bounce_held", int'(key_held), 0);

    // Keys (1,2) and (3,2) together: row 1 wins, code 6, one pulse.
    do_reset("two");
    exp_q.push_back(6);
    pressed[1][2] = 1'b1;
    pressed[3][2] = 1'b1;
    clks(100);
    chk("two_pending", exp_q.size(), 0);
    chk("two_code", int'(key_code), 6);
    pressed = '0;
    clks(30);
    chk("two_held_after_release", int'(key_held), 0);

    // Key (3,0) accepted, 1-tick release glitch: stays held, no second pulse.
    do_reset("glitch");
    exp_q.push_back(12);
    pressed[3][0] = 1'b1;
    clks(100);
    chk("glitch_pending", exp_q.size(), 0);
    pressed = '0;
    clks(4);
    pressed[3][0] = 1'b1;
    dropped = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_held !== 1'b1) dropped++;
    end
    chk("glitch_held_dropped_cycles", dropped, 0);
    chk("glitch_code", int'(key_code), 12);
    pressed = '0;
    clks(30);

    // Reset during PRESS_DB of key (1,1): aborted, then re-debounced afresh.
    do_reset("abort");
    pressed[1][1] = 1'b1;
    clks(10);
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_col", int'(col), 4'b1110);
    chk("abort_valid", int'(key_valid), 0);
    chk("abort_code", int'(key_code), 0);
    chk("abort_held", int'(key_held), 0);
    exp_q.push_back(5);
    clks(60);
    chk("abort_pending", exp_q.size(), 0);
    chk("abort_code_after", int'(key_code), 5);
    pressed = '0;
    clks(30);

    chk("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
